// File: rtl/l2_sync_reservation_unit.sv
// Load-linked / store-conditional reservation tracker for the L2 pipeline.
// Holds one line reservation per (core, thread) and answers each STORE_SYNC one cycle later.
package l2_sync_reservation_pkg;

  typedef enum logic [2:0] {
    L2REQ_LOAD        = 3'd0,
    L2REQ_STORE       = 3'd1,
    L2REQ_LOAD_SYNC   = 3'd2,
    L2REQ_STORE_SYNC  = 3'd3,
    L2REQ_IINVALIDATE = 3'd4,
    L2REQ_DINVALIDATE = 3'd5,
    L2REQ_FLUSH       = 3'd6,
    L2REQ_MEMBAR      = 3'd7
  } l2req_packet_type_t;

endpackage

module l2_sync_reservation_unit
  import l2_sync_reservation_pkg::*;
#(
  parameter int unsigned NUM_CORES        = 1,
  parameter int unsigned THREADS_PER_CORE = 4,
  parameter int unsigned CORE_IDX_WIDTH   = 1,
  parameter int unsigned ID_WIDTH         = 2,
  parameter int unsigned LINE_ADDR_WIDTH  = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  l2req_packet_type_t         req_packet_type,
  input  logic [CORE_IDX_WIDTH-1:0]  req_core,
  input  logic [ID_WIDTH-1:0]        req_id,
  input  logic [LINE_ADDR_WIDTH-1:0] req_line_addr,
  output logic                       rsp_valid,
  output logic                       rsp_success,
  output logic [CORE_IDX_WIDTH-1:0]  rsp_core,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic                       perf_sync_success,
  output logic                       perf_sync_fail
);

  localparam int unsigned NUM_SLOTS = NUM_CORES * THREADS_PER_CORE;

  logic [NUM_SLOTS-1:0]       valid_q, valid_d;
  logic [LINE_ADDR_WIDTH-1:0] addr_q [NUM_SLOTS];
  logic [LINE_ADDR_WIDTH-1:0] addr_d [NUM_SLOTS];

  logic [31:0]                slot_idx;
  logic [NUM_SLOTS-1:0]       own_sel;
  logic [NUM_SLOTS-1:0]       line_match;
  logic                       own_valid;
  logic [LINE_ADDR_WIDTH-1:0] own_addr;
  logic                       hit;

  logic                       is_load_sync;
  logic                       is_store_sync;
  logic                       is_store;

  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_success_q, rsp_success_d;
  logic [CORE_IDX_WIDTH-1:0]  rsp_core_q, rsp_core_d;
  logic [ID_WIDTH-1:0]        rsp_id_q, rsp_id_d;
  logic                       perf_success_q, perf_success_d;
  logic                       perf_fail_q, perf_fail_d;

  assign slot_idx      = 32'(req_core) * 32'(THREADS_PER_CORE) + 32'(req_id);
  assign is_load_sync  = req_valid && (req_packet_type == L2REQ_LOAD_SYNC);
  assign is_store_sync = req_valid && (req_packet_type == L2REQ_STORE_SYNC);
  assign is_store      = req_valid && (req_packet_type == L2REQ_STORE);

  // Decode own slot and find every live reservation on the requested line.
  always_comb begin
    own_sel    = '0;
    line_match = '0;
    own_addr   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      own_sel[i]    = (slot_idx == 32'(i));
      line_match[i] = valid_q[i] && (addr_q[i] == req_line_addr);
      if (own_sel[i]) begin
        own_addr = own_addr | addr_q[i];
      end
    end
    own_valid = |(valid_q & own_sel);
    hit       = own_valid && (own_addr == req_line_addr);
  end

  // Reservation table next state; a winning or plain store kills every copy of the line.
  always_comb begin
    valid_d = valid_q;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      addr_d[i] = addr_q[i];
    end
    if (is_load_sync) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (own_sel[i]) begin
          valid_d[i] = 1'b1;
          addr_d[i]  = req_line_addr;
        end
      end
    end else if (is_store || (is_store_sync && hit)) begin
      valid_d = valid_q & ~line_match;
    end else if (is_store_sync) begin
      valid_d = valid_q & ~own_sel;
    end
  end

  // Response registers: payload holds between store-syncs, strobes do not.
  always_comb begin
    rsp_valid_d    = is_store_sync;
    perf_success_d = is_store_sync && hit;
    perf_fail_d    = is_store_sync && !hit;
    rsp_success_d  = rsp_success_q;
    rsp_core_d     = rsp_core_q;
    rsp_id_d       = rsp_id_q;
    if (is_store_sync) begin
      rsp_success_d = hit;
      rsp_core_d    = req_core;
      rsp_id_d      = req_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_success_q  <= 1'b0;
      rsp_core_q     <= '0;
      rsp_id_q       <= '0;
      perf_success_q <= 1'b0;
      perf_fail_q    <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_success_q  <= rsp_success_d;
      rsp_core_q     <= rsp_core_d;
      rsp_id_q       <= rsp_id_d;
      perf_success_q <= perf_success_d;
      perf_fail_q    <= perf_fail_d;
    end
  end

  // Line addresses are only meaningful under their valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      addr_q[i] <= addr_d[i];
    end
  end

  assign rsp_valid         = rsp_valid_q;
  assign rsp_success       = rsp_success_q;
  assign rsp_core          = rsp_core_q;
  assign rsp_id            = rsp_id_q;
  assign perf_sync_success = perf_success_q;
  assign perf_sync_fail    = perf_fail_q;

endmodule

// File: doc/l2_sync_reservation_unit.md
Name: l2_sync_reservation_unit

Overview:
Responder-side tracker for synchronized (load-linked / store-conditional) accesses in the L2 pipeline.
- One reservation is held per (core, thread) requester.
- On each STORE_SYNC the unit decides success or failure and returns it one cycle later, to the stage that builds the L2RSP_STORE_ACK status bit and gates the cache write.
- Plain stores and successful sync stores clear every reservation on the same line, so a losing thread in a race gets status=0.

Parameters:
NUM_CORES, 1, number of requesting cores
THREADS_PER_CORE, 4, reservation slots per core; the request id selects the slot
CORE_IDX_WIDTH, 1, width of the core field (at least 1)
ID_WIDTH, 2, width of the thread id field
LINE_ADDR_WIDTH, 26, cache-line address width (32-bit address minus the 6 offset bits)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  request present in this stage this cycle (at most one per cycle)
req_packet_type  in  l2req_packet_type_t  L2REQ_LOAD, L2REQ_STORE, L2REQ_LOAD_SYNC, L2REQ_STORE_SYNC, others
req_core  in  CORE_IDX_WIDTH  requesting core
req_id  in  ID_WIDTH  requesting thread
req_line_addr  in  LINE_ADDR_WIDTH  cache-line address
rsp_valid  out  1  pulses one cycle after each accepted STORE_SYNC
rsp_success  out  1  store-sync result; qualified by rsp_valid
rsp_core  out  CORE_IDX_WIDTH  echo of the core of the STORE_SYNC being answered
rsp_id  out  ID_WIDTH  echo of the id of the STORE_SYNC being answered
perf_sync_success  out  1  one-cycle pulse with each successful response
perf_sync_fail  out  1  one-cycle pulse with each failed response

Behaviour:
- Storage: NUM_CORES*THREADS_PER_CORE entries, each {valid, line_addr}. Slot index = req_core*THREADS_PER_CORE + req_id.
- Reset (asynchronous): all valid bits = 0. rsp_valid, rsp_success, rsp_core, rsp_id and both perf outputs = 0. Contents of line_addr are don't-care.
- All table updates happen on the clk edge that samples req_valid=1.
- LOAD_SYNC: own slot is set to {1, req_line_addr}, overwriting any prior reservation. No response is produced.
- STORE_SYNC: hit = own.valid && own.line_addr == req_line_addr.
  - On hit: every entry (own included) whose valid=1 and line_addr == req_line_addr is cleared.
  - On miss: only own slot is cleared; all other entries are unchanged.
  - The next cycle: rsp_valid=1, rsp_success=hit, rsp_core/rsp_id = request fields, and the matching perf pulse.
  - Latency is exactly 1 cycle. Output registers hold their values but rsp_valid drops to 0 when there is no STORE_SYNC.
- STORE (plain): clears every valid entry matching req_line_addr. No response is produced.
- LOAD and all other types: no effect on the table.
- Back-to-back STORE_SYNCs to the same line (1-cycle spacing): the second must see the invalidation made by the first. The table update must be visible to the compare on the next request, with no one-cycle hazard.
- A STORE_SYNC after a LOAD_SYNC to a different line by the same slot fails. The earlier reservation on the other line was already overwritten by the LOAD_SYNC.
- Reset asserted mid-stream: any pending response is dropped (rsp_valid=0) and all reservations are lost. A STORE_SYNC issued after reset release fails.
- The unit does not stall and has no back-pressure. The upstream stage guarantees at most one request per cycle.

Test Plan:
- LOAD_SYNC core0/id0 line 0x4 (address 0x123), then STORE_SYNC same -> rsp_valid 1 cycle later, rsp_success=1, rsp_id=0, perf_sync_success pulse.
- LOAD_SYNC id1 and id2 on line 0x4; STORE_SYNC id1 then STORE_SYNC id2 on consecutive cycles -> id1 success=1, id2 success=0, perf_sync_fail pulse for id2.
- LOAD_SYNC id3 line 0x4; plain STORE line 0x4 from id0; STORE_SYNC id3 -> success=0.
- LOAD_SYNC id1 line 0x4 and id2 line 0x8; STORE_SYNC id1 line 0x4 -> success=1. Then STORE_SYNC id2 line 0x8 -> success=1 (a different line is unaffected).
- STORE_SYNC id0 with no prior LOAD_SYNC -> success=0. A repeated STORE_SYNC after a successful one without a new LOAD_SYNC -> success=0.
- LOAD_SYNC id0 line 0x4; assert reset for 2 cycles while a STORE_SYNC is in flight -> no rsp_valid. Post-reset STORE_SYNC id0 line 0x4 -> success=0.
